// File: rtl/pa_rsp_slave.sv
// In-order request/response slave: buffers PA requests, answers each with (PA ^ KEY) once it has aged LAT cycles.
// Optional macro PA_RSP_SLAVE_ERR_EN adds PERR, flagging unaligned head addresses (PD forced to 0).
module pa_rsp_slave #(
  parameter int              PW    = 32,
  parameter int              DW    = 32,
  parameter int              DEPTH = 4,
  parameter int              LAT   = 2,
  parameter logic [PW-1:0]   KEY   = '0
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [PW-1:0] PA,
  input  logic          QVALID,
  output logic          QREADY,
  output logic          PVALID,
  input  logic          PREADY,
  output logic [DW-1:0] PD
`ifdef PA_RSP_SLAVE_ERR_EN
  ,
  output logic          PERR
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT4   = 4'(LAT);
  localparam logic [AW:0] DEPTHC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   mem_d [DEPTH];
  logic [3:0]      age_q [DEPTH];
  logic [3:0]      age_d [DEPTH];
  logic            qready_q, qready_d;
  logic            pvalid_q, pvalid_d;
  logic [DW-1:0]   pd_q, pd_d;
  logic            perr_q, perr_d;

  logic            push, pop;
  logic            head_ready_d;
  logic [PW-1:0]   head_pa_d;
  logic [PW-1:0]   head_key_d;

  // Anything other than a clean 1 on the handshakes counts as idle.
  assign push = (QVALID === 1'b1) && qready_q;
  assign pop  = (PREADY === 1'b1) && pvalid_q;

  always_comb begin
    mem_d    = mem_q;
    age_d    = age_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_q[i] < LAT4) age_d[i] = age_q[i] + 4'd1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = PA;
      age_d[wr_ptr_q] = '0;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign head_ready_d = (age_d[rd_ptr_d] == LAT4);
  assign head_pa_d    = mem_d[rd_ptr_d];
  assign head_key_d   = head_pa_d ^ KEY;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (push) state_d = ST_WAIT;
      ST_WAIT: if (head_ready_d) state_d = ST_RESP;
      ST_RESP: begin
        if (pop) begin
          if (cnt_d == '0)       state_d = ST_IDLE;
          else if (head_ready_d) state_d = ST_RESP;
          else                   state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    qready_d = (cnt_d < DEPTHC);
    pvalid_d = (state_d == ST_RESP);
    perr_d   = 1'b0;
    pd_d     = '0;
    if (pvalid_d) begin
`ifdef PA_RSP_SLAVE_ERR_EN
      perr_d = (head_pa_d[1:0] != 2'b00);
`endif
      pd_d = perr_d ? '0 : DW'(head_key_d);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      qready_q <= 1'b0;
      pvalid_q <= 1'b0;
      pd_q     <= '0;
      perr_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qready_q <= qready_d;
      pvalid_q <= pvalid_d;
      pd_q     <= pd_d;
      perr_q   <= perr_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Payload storage needs no reset; occupancy and ages gate every use of it.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign QREADY = qready_q;
  assign PVALID = pvalid_q;
  assign PD     = pd_q;
`ifdef PA_RSP_SLAVE_ERR_EN
  assign PERR   = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: doc/pa_rsp_slave.md
PA_RSP_SLAVE -- requirements
Module: pa_rsp_slave

Interface
REQ-001 Parameter PW, 32, physical address width.
REQ-002 Parameter DW, 32, response data width.
REQ-003 Parameter DEPTH, 4, request buffer entries; power of two, 2..16.
REQ-004 Parameter LAT, 2, minimum cycles from request acceptance to response; range 1..15.
REQ-005 Parameter KEY, 32'h0000_0000, XOR mask applied to the stored address to form response data.
REQ-006 One clock; reset is asynchronous and active-low: CLK input, RSTN input.
REQ-007 CLK  input  1  rising-edge clock.
REQ-008 RSTN  input  1  asynchronous active-low reset.
REQ-009 PA  input  PW  request physical address, sampled on acceptance.
REQ-010 QVALID  input  1  request valid.
REQ-011 QREADY  output  1  request ready.
REQ-012 PVALID  output  1  response valid.
REQ-013 PREADY  input  1  response ready.
REQ-014 PD  output  DW  response data.

Function
REQ-015 Request accepted on a CLK rising edge where QVALID=1 and QREADY=1; PA pushed into an in-order buffer.
REQ-016 QREADY = (occupancy < DEPTH), derived only from registered occupancy; a pop in the same cycle does not raise QREADY when full.
REQ-017 Each entry carries a 4-bit age counter: cleared to 0 on acceptance, incremented every cycle, saturating at LAT.
REQ-018 Output FSM states: IDLE (buffer empty), WAIT (head age < LAT), RESP (PVALID=1).
REQ-019 IDLE->WAIT on acceptance into an empty buffer; WAIT->RESP on the edge where head age reaches LAT; RESP->RESP/WAIT/IDLE on pop, by next head age and occupancy.
REQ-020 A request accepted at edge n produces PVALID=1 no earlier than after edge n+LAT.
REQ-021 Response pop on a rising edge where PVALID=1 and PREADY=1; the head is removed.
REQ-022 PVALID and PD are registered; once PVALID=1, PVALID and PD stay stable until the pop.
REQ-023 PD = zero-extended or truncated (head PA XOR KEY[PW-1:0]) to DW bits.
REQ-024 Ages run regardless of buffer position, so queued entries older than LAT respond back-to-back, one per cycle, with no bubble.
REQ-025 Simultaneous push and pop at nonzero occupancy leaves occupancy unchanged.
REQ-026 Push into empty with LAT=1 gives PVALID after the next edge.
REQ-027 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Occupancy is log2(DEPTH)+1 bits.
REQ-029 Responses are returned strictly in acceptance order.
REQ-030 X on QVALID or PREADY is treated as 0 (no accept, no pop).

Reset
REQ-031 RSTN=0 immediately, without waiting for CLK, forces: QREADY=0, PVALID=0, PD=0, FSM=IDLE, occupancy=0, pointers=0, all ages=0.
REQ-032 The first rising edge with RSTN=1 sets QREADY=1.
REQ-033 Reset mid-operation discards all buffered requests; no response is issued for them.

Configuration
REQ-034 Macro PA_RSP_SLAVE_ERR_EN, when defined, adds output PERR (1 bit, reset 0).
REQ-035 With PA_RSP_SLAVE_ERR_EN defined: PERR=1 alongside PVALID when the head PA[1:0]!=0; PERR is held with PD and PD is forced to 0 for that response.
REQ-036 With PA_RSP_SLAVE_ERR_EN undefined: PERR port is absent and unaligned addresses are handled like any other address.

Verification
REQ-037 Single request, LAT=2, KEY=0: PA=32'h1000 accepted at edge 5 -> PVALID=1 after edge 7, PD=32'h1000; with PREADY=1, PVALID=0 after edge 8.
REQ-038 Fill with PREADY=0: DEPTH=4, PA=1,2,3,4 on consecutive cycles -> QREADY=0 after the 4th accept; a 5th request is held. Then PREADY=1 -> PD=1,2,3,4 on consecutive cycles and QREADY returns 1 after the first pop edge.
REQ-039 Backpressure: PVALID=1 with PD=32'hABCD, PREADY=0 for 3 cycles -> PVALID and PD unchanged for all 3 cycles.
REQ-040 Simultaneous push and pop with occupancy 2 -> occupancy stays 2, order preserved; wrap check: 10 requests through DEPTH=4 -> in-order data, no loss.
REQ-041 Async reset: RSTN=0 mid-cycle with 3 entries -> PVALID and QREADY drop before the next edge; no response for those 3 after release.
REQ-042 With PA_RSP_SLAVE_ERR_EN: PA=32'h1002 -> PERR=1, PD=0; PA=32'h1004 -> PERR=0, PD=32'h1004 XOR KEY.
